uart_tx_fifo: RTL and testbench

- Elastic buffer directly upstream of uart_tx.
- Accepts words from a producer over a valid/ready handshake and stores up to DEPTH of them.
- Presents the oldest word to uart_tx (i_vld/i_data/o_rdy) in first-word-fall-through order.
- Decouples bursty producers from the slow serial line and exposes fill status for flow control.

---
 rtl/uart_tx_fifo.sv | 96 +++++++++
 tb/tb_uart_tx_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through elastic buffer feeding uart_tx, DEPTH x DATA_WIDTH.
// Latency: a word pushed at edge N is on o_vld/o_data after edge N; no empty-FIFO bypass.
// Backpressure: o_rdy is registered from stored occupancy; a same-cycle pop never frees a full FIFO.
// Optional: define UART_TX_FIFO_FLUSH_EN to add i_flush (synchronous clear overriding push/pop).
module uart_tx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_vld,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic                    o_rdy,
  output logic                    o_vld,
  output logic [DATA_WIDTH-1:0]   o_data,
  input  logic                    i_rdy,
`ifdef UART_TX_FIFO_FLUSH_EN
  input  logic                    i_flush,
`endif
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_empty,
  output logic                    o_afull
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic        rdy_q, rdy_d;
  logic        push, pop, flush;

`ifdef UART_TX_FIFO_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  // Handshakes are qualified by registered state only, so o_rdy never depends on i_rdy.
  assign push = i_vld && rdy_q;
  assign pop  = (count_q != '0) && i_rdy;

  // Next pointers, occupancy and ready; flush wins over any transfer in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
    // Full when address bits match but the wrap bits differ.
    rdy_d = !((wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]));
  end

  // Control state; reset discards stored words and holds o_rdy low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdy_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdy_q    <= rdy_d;
    end
  end

  // Storage array is not reset; a flushed push is not written.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

  assign o_rdy   = rdy_q;
  assign o_vld   = (count_q != '0);
  assign o_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign o_count = count_q;
  assign o_empty = (count_q == '0);
  assign o_afull = (count_q >= AFULL_C);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at DEPTH=4, AFULL_THRESH=3, DATA_WIDTH=7.
// A queue model predicts every output each cycle; directed phases pin literal values.
module tb_uart_tx_fifo;
  localparam int DW    = 7;
  localparam int DEPTH = 4;
  localparam int AF    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_vld = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          i_rdy = 1'b0;
  logic          tb_flush = 1'b0;
  logic          o_rdy, o_vld, o_empty, o_afull;
  logic [DW-1:0] o_data;
  logic [2:0]    o_count;

  int tests = 0;
  int fails = 0;

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF)) dut (
    .clk(clk), .rst(rst),
    .i_vld(i_vld), .i_data(i_data), .o_rdy(o_rdy),
    .o_vld(o_vld), .o_data(o_data), .i_rdy(i_rdy),
`ifdef UART_TX_FIFO_FLUSH_EN
    .i_flush(tb_flush),
`endif
    .o_count(o_count), .o_empty(o_empty), .o_afull(o_afull)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the registered ready bit.
  logic [DW-1:0] mq[$];
  bit m_rdy = 1'b0;
  bit m_push, m_pop;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_rdy = 1'b0;
    end else begin
      m_push = i_vld && m_rdy;
      m_pop  = (mq.size() != 0) && i_rdy;
      if (tb_flush) begin
        mq.delete();
      end else begin
        if (m_pop)  void'(mq.pop_front());
        if (m_push) mq.push_back(i_data);
      end
      m_rdy = (mq.size() < DEPTH);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_vld",   o_vld,   32'(mq.size() != 0));
    chk("m_count", o_count, 32'(mq.size()));
    chk("m_empty", o_empty, 32'(mq.size() == 0));
    chk("m_afull", o_afull, 32'(mq.size() >= AF));
    chk("m_rdy",   o_rdy,   32'(m_rdy));
    if (mq.size() != 0) chk("m_data", o_data, 32'(mq[0]));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    i_vld  = 1'b1;
    i_data = d;
    tick();
    i_vld  = 1'b0;
  endtask

  logic [DW-1:0] seq [4];
  bit acc;

  initial begin
    seq[0] = 7'h11; seq[1] = 7'h22; seq[2] = 7'h33; seq[3] = 7'h44;

    // Power-on reset state, then ready one edge after release.
    #3;
    chk("rst_vld",   o_vld,   0);
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_rdy",   o_rdy,   0);
    chk("rst_afull", o_afull, 0);
    #9 rst = 1'b1;
    #1 chk("rel_rdy_pre", o_rdy, 0);
    tick();
    chk("rel_rdy_post", o_rdy, 1);

    // Fill to full with the consumer stalled.
    i_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push_word(seq[k]);
      chk("fill_count", o_count, k + 1);
      chk("fill_afull", o_afull, (k + 1) >= AF);
      chk("fill_rdy",   o_rdy,   (k + 1) < DEPTH);
    end
    i_vld = 1'b1; i_data = 7'h55;
    tick(); tick();
    chk("full_count", o_count, 4);
    chk("full_rdy",   o_rdy,   0);
    i_vld = 1'b0;

    // Drain in push order on consecutive cycles.
    chk("drain_head", o_data, 7'h11);
    i_rdy = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("drain_data", o_data, seq[k]);
    end
    tick();
    chk("drain_empty", o_empty, 1);
    chk("drain_vld",   o_vld,   0);
    i_rdy = 1'b0;

    // Push and pop together at count 1: new word becomes head.
    push_word(7'h0A);
    chk("c1_count", o_count, 1);
    i_vld = 1'b1; i_data = 7'h0B; i_rdy = 1'b1;
    tick();
    i_vld = 1'b0; i_rdy = 1'b0;
    chk("c1_data",  o_data,  7'h0B);
    chk("c1_count2", o_count, 1);
    chk("c1_vld",   o_vld,   1);
    i_rdy = 1'b1; tick(); i_rdy = 1'b0;
    chk("c1_empty", o_empty, 1);

    // Random producer against a mostly-stalled, then faster, consumer.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = i_vld && o_rdy;
      @(posedge clk);
      #1;
      if (!i_vld || acc) begin
        i_vld  = ($urandom_range(0, 99) < 60);
        i_data = DW'($urandom);
      end
      i_rdy = ($urandom_range(0, 99) < ((c < 1500) ? 25 : 70));
    end
    @(negedge clk);
    acc = i_vld && o_rdy;
    @(posedge clk);
    #1;
    if (!acc) begin
      // Hold the pending word until it is taken.
      for (int w = 0; w < 20 && !acc; w++) begin
        i_rdy = 1'b1;
        @(negedge clk);
        acc = i_vld && o_rdy;
        tick();
      end
    end
    i_vld = 1'b0;
    i_rdy = 1'b1;
    repeat (8) tick();
    i_rdy = 1'b0;
    chk("rand_drained", o_empty, 1);

    // Asynchronous reset mid-operation with three words stored.
    for (int k = 0; k < 3; k++) push_word(DW'(k + 3));
    chk("mid_count", o_count, 3);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_vld",   o_vld,   0);
    chk("mid_count0", o_count, 0);
    chk("mid_empty", o_empty, 1);
    chk("mid_rdy",   o_rdy,   0);
    chk("mid_afull", o_afull, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    tick();
    chk("mid_rel_rdy", o_rdy, 1);

`ifdef UART_TX_FIFO_FLUSH_EN
    // Flush overrides a same-cycle push.
    for (int k = 0; k < 3; k++) push_word(DW'(k + 0x20));
    chk("fl_count3", o_count, 3);
    tb_flush = 1'b1; i_vld = 1'b1; i_data = 7'h7F;
    tick();
    tb_flush = 1'b0; i_vld = 1'b0;
    chk("fl_count", o_count, 0);
    chk("fl_vld",   o_vld,   0);
    chk("fl_rdy",   o_rdy,   1);
    push_word(7'h01);
    chk("fl_next", o_data, 7'h01);
    i_rdy = 1'b1; tick(); i_rdy = 1'b0;
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
